bigblade_clk_gen_tag_seq: RTL and testbench

- Upstream bsg_tag serial sequencer for one clock-generator instance (async-reset, select, osc, osc-trigger and ds tag clients).
- Runs on the tag clock and, on a start pulse, emits a fixed ordered stream of bsg_tag packets on the serial tag data line. The sequence resets the oscillator, programs and triggers it, resets and programs the downsampler, releases reset, and selects the output clock.
- Used during bring-up and by the on-chip boot controller, so the clock generator needs no off-chip tag master.

---
 rtl/bigblade_clk_gen_tag_seq.sv | 170 +++++++++++++++++
 tb/tb_bigblade_clk_gen_tag_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bigblade_clk_gen_tag_seq.sv
// rtl/bigblade_clk_gen_tag_seq.sv - bsg_tag serial sequencer for one clock-generator instance
module bigblade_clk_gen_tag_seq #(
  parameter int ds_width_p      = 8,
  parameter int osc_width_p     = 5,
  parameter int node_id_width_p = 5,
  parameter int len_width_p     = 4,
  parameter int gap_cycles_p    = 4,
  parameter int id_reset_p      = 0,
  parameter int id_sel_p        = 1,
  parameter int id_osc_p        = 2,
  parameter int id_trig_p       = 3,
  parameter int id_ds_p         = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   init_i,
  input  logic [osc_width_p-1:0] osc_i,
  input  logic [ds_width_p-1:0]  ds_i,
  input  logic [1:0]             sel_i,
  output logic                   tag_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int pay_a_lp  = (ds_width_p + 1 > osc_width_p) ? ds_width_p + 1 : osc_width_p;
  localparam int pay_w_lp  = (pay_a_lp > 2) ? pay_a_lp : 2;
  localparam int fmax_a_lp = (gap_cycles_p > node_id_width_p) ? gap_cycles_p : node_id_width_p;
  localparam int fmax_b_lp = (len_width_p > pay_w_lp) ? len_width_p : pay_w_lp;
  localparam int fmax_lp   = (fmax_a_lp > fmax_b_lp) ? fmax_a_lp : fmax_b_lp;
  localparam int cnt_w_lp  = $clog2(fmax_lp + 1);

  localparam logic [3:0] first_cfg_lp = 4'd5;
  localparam logic [3:0] last_pkt_lp  = 4'd12;

  localparam logic [2:0] idle_s    = 3'd0;
  localparam logic [2:0] gap_s     = 3'd1;
  localparam logic [2:0] start_s   = 3'd2;
  localparam logic [2:0] id_s      = 3'd3;
  localparam logic [2:0] dnr_s     = 3'd4;
  localparam logic [2:0] len_s     = 3'd5;
  localparam logic [2:0] payload_s = 3'd6;
  localparam logic [2:0] done_s    = 3'd7;

  logic [2:0]             state_r;
  logic [cnt_w_lp-1:0]    bit_cnt_r;
  logic [3:0]             pkt_idx_r;
  logic [osc_width_p-1:0] osc_r;
  logic [ds_width_p-1:0]  ds_r;
  logic [1:0]             sel_r;

  logic [node_id_width_p-1:0] pkt_id;
  logic [len_width_p-1:0]     pkt_len;
  logic                       pkt_dnr;
  logic [pay_w_lp-1:0]        pkt_pay;

  // Packets 0..4 clear each client (dnr=0, zero payload); 5..12 program it.
  always_comb begin
    pkt_id  = '0;
    pkt_len = '0;
    pkt_dnr = (pkt_idx_r >= first_cfg_lp);
    pkt_pay = '0;
    case (pkt_idx_r)
      4'd0:  begin pkt_id = node_id_width_p'(id_reset_p); pkt_len = len_width_p'(1); end
      4'd1:  begin pkt_id = node_id_width_p'(id_sel_p);   pkt_len = len_width_p'(2); end
      4'd2:  begin pkt_id = node_id_width_p'(id_osc_p);   pkt_len = len_width_p'(osc_width_p); end
      4'd3:  begin pkt_id = node_id_width_p'(id_trig_p);  pkt_len = len_width_p'(1); end
      4'd4:  begin pkt_id = node_id_width_p'(id_ds_p);    pkt_len = len_width_p'(ds_width_p + 1); end
      4'd5:  begin pkt_id = node_id_width_p'(id_reset_p); pkt_len = len_width_p'(1); pkt_pay = pay_w_lp'(1); end
      4'd6:  begin pkt_id = node_id_width_p'(id_osc_p);   pkt_len = len_width_p'(osc_width_p); pkt_pay = pay_w_lp'(osc_r); end
      4'd7:  begin pkt_id = node_id_width_p'(id_trig_p);  pkt_len = len_width_p'(1); pkt_pay = pay_w_lp'(1); end
      4'd8:  begin pkt_id = node_id_width_p'(id_trig_p);  pkt_len = len_width_p'(1); end
      4'd9:  begin pkt_id = node_id_width_p'(id_ds_p);    pkt_len = len_width_p'(ds_width_p + 1); pkt_pay = pay_w_lp'({ds_r, 1'b1}); end
      4'd10: begin pkt_id = node_id_width_p'(id_ds_p);    pkt_len = len_width_p'(ds_width_p + 1); pkt_pay = pay_w_lp'({ds_r, 1'b0}); end
      4'd11: begin pkt_id = node_id_width_p'(id_reset_p); pkt_len = len_width_p'(1); end
      4'd12: begin pkt_id = node_id_width_p'(id_sel_p);   pkt_len = len_width_p'(2); pkt_pay = pay_w_lp'(sel_r); end
      default: ;
    endcase
  end

  int         field_len;
  logic [2:0] field_next;
  logic       last_bit;

  always_comb begin
    field_len  = 1;
    field_next = idle_s;
    case (state_r)
      gap_s:     begin field_len = gap_cycles_p;    field_next = start_s;   end
      start_s:   begin field_len = 1;               field_next = id_s;      end
      id_s:      begin field_len = node_id_width_p; field_next = dnr_s;     end
      dnr_s:     begin field_len = 1;               field_next = len_s;     end
      len_s:     begin field_len = len_width_p;     field_next = payload_s; end
      payload_s: begin field_len = int'(pkt_len);   field_next = gap_s;     end
      default: ;
    endcase
    last_bit = (int'(bit_cnt_r) == field_len - 1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= idle_s;
      bit_cnt_r <= '0;
      pkt_idx_r <= '0;
      osc_r     <= '0;
      ds_r      <= '0;
      sel_r     <= '0;
    end else begin
      case (state_r)
        idle_s: begin
          if (start_i) begin
            osc_r     <= osc_i;
            ds_r      <= ds_i;
            sel_r     <= sel_i;
            pkt_idx_r <= init_i ? 4'd0 : first_cfg_lp;
            bit_cnt_r <= '0;
            state_r   <= gap_s;
          end
        end
        gap_s, start_s, id_s, dnr_s, len_s: begin
          if (last_bit) begin
            bit_cnt_r <= '0;
            state_r   <= field_next;
          end else begin
            bit_cnt_r <= bit_cnt_r + cnt_w_lp'(1);
          end
        end
        payload_s: begin
          if (last_bit) begin
            bit_cnt_r <= '0;
            if (pkt_idx_r == last_pkt_lp) begin
              state_r <= done_s;
            end else begin
              pkt_idx_r <= pkt_idx_r + 4'd1;
              state_r   <= gap_s;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + cnt_w_lp'(1);
          end
        end
        default: state_r <= idle_s;
      endcase
    end
  end

  logic [node_id_width_p-1:0] id_sh;
  logic [len_width_p-1:0]     len_sh;
  logic [pay_w_lp-1:0]        pay_sh;

  assign id_sh  = pkt_id >> bit_cnt_r;
  assign len_sh = pkt_len >> bit_cnt_r;
  assign pay_sh = pkt_pay >> bit_cnt_r;

  // Output is a pure decode of registered state, so async reset forces it low at once.
  always_comb begin
    tag_data_o = 1'b0;
    case (state_r)
      start_s:   tag_data_o = 1'b1;
      id_s:      tag_data_o = id_sh[0];
      dnr_s:     tag_data_o = pkt_dnr;
      len_s:     tag_data_o = len_sh[0];
      payload_s: tag_data_o = pay_sh[0];
      default:   tag_data_o = 1'b0;
    endcase
  end

  assign busy_o = (state_r != idle_s) && (state_r != done_s);
  assign done_o = (state_r == done_s);

endmodule

// File: tb/tb_bigblade_clk_gen_tag_seq.sv
// tb/tb_bigblade_clk_gen_tag_seq.sv - directed self-checking bench for bigblade_clk_gen_tag_seq
module tb_bigblade_clk_gen_tag_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       init;
  logic [4:0] osc;
  logic [7:0] ds;
  logic [1:0] sel;
  logic       tag_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  bigblade_clk_gen_tag_seq dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .init_i     (init),
    .osc_i      (osc),
    .ds_i       (ds),
    .sel_i      (sel),
    .tag_data_o (tag_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic cap_tag  [0:319];
  logic cap_busy [0:319];
  logic cap_done [0:319];
  int   cap_n;

  logic exp_bits [0:319];
  int   exp_n;
  int   expp [0:31];
  int   expp_n;
  int   dec_pkt [0:31];
  int   dec_n;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pack(input int id, input int dnr, input int len, input int pay);
    return (id << 24) | (dnr << 20) | (len << 16) | pay;
  endfunction

  task automatic set_pkts(input bit with_init);
    expp_n = 0;
    if (with_init) begin
      expp[expp_n++] = pack(0, 0, 1, 0);
      expp[expp_n++] = pack(1, 0, 2, 0);
      expp[expp_n++] = pack(2, 0, 5, 0);
      expp[expp_n++] = pack(3, 0, 1, 0);
      expp[expp_n++] = pack(4, 0, 9, 0);
    end
    expp[expp_n++] = pack(0, 1, 1, 1);
    expp[expp_n++] = pack(2, 1, 5, 'h15);
    expp[expp_n++] = pack(3, 1, 1, 1);
    expp[expp_n++] = pack(3, 1, 1, 0);
    expp[expp_n++] = pack(4, 1, 9, 'h007);
    expp[expp_n++] = pack(4, 1, 9, 'h006);
    expp[expp_n++] = pack(0, 1, 1, 0);
    expp[expp_n++] = pack(1, 1, 2, 1);
  endtask

  task automatic put_bit(input logic b);
    exp_n++;
    exp_bits[exp_n] = b;
  endtask

  // Expected serial stream built from the packet list, starting in cycle 1.
  task automatic build_stream();
    int p, id, dnr, len, pay;
    for (int i = 0; i < 320; i++) exp_bits[i] = 1'b0;
    exp_n = 0;
    for (p = 0; p < expp_n; p++) begin
      id  = (expp[p] >> 24) & 'hff;
      dnr = (expp[p] >> 20) & 1;
      len = (expp[p] >> 16) & 'hf;
      pay = expp[p] & 'hffff;
      for (int g = 0; g < 4; g++) put_bit(1'b0);
      put_bit(1'b1);
      for (int k = 0; k < 5; k++) put_bit(logic'((id >> k) & 1));
      put_bit(logic'(dnr));
      for (int k = 0; k < 4; k++) put_bit(logic'((len >> k) & 1));
      for (int k = 0; k < len; k++) put_bit(logic'((pay >> k) & 1));
    end
  endtask

  function automatic int tbit(input int i);
    if (i >= 1 && i <= cap_n) return int'(cap_tag[i]);
    return 0;
  endfunction

  // Receiver-side bsg_tag model: idle zeros, then start bit, id, dnr, len, payload.
  task automatic decode();
    int i, id, dnr, len, pay;
    dec_n = 0;
    i = 1;
    while (i <= cap_n) begin
      if (tbit(i) == 0) begin
        i++;
      end else begin
        i++;
        id = 0; len = 0; pay = 0;
        for (int k = 0; k < 5; k++) id |= tbit(i++) << k;
        dnr = tbit(i++);
        for (int k = 0; k < 4; k++) len |= tbit(i++) << k;
        for (int k = 0; k < len; k++) pay |= tbit(i++) << k;
        if (dec_n < 32) dec_pkt[dec_n] = pack(id, dnr, len, pay);
        dec_n++;
      end
    end
  endtask

  task automatic check_pkts(input string tag);
    decode();
    check({tag, "_pkt_count"}, dec_n, expp_n);
    for (int k = 0; k < expp_n && k < dec_n; k++)
      check($sformatf("%s_pkt%0d", tag, k), dec_pkt[k], expp[k]);
  endtask

  task automatic check_stream(input string tag);
    int bad;
    bad = -1;
    for (int c = 1; c <= cap_n; c++)
      if (bad < 0 && cap_tag[c] !== exp_bits[c]) bad = c;
    check({tag, "_stream_first_bad_cycle"}, bad, -1);
  endtask

  task automatic check_done_busy(input string tag, input int done_cyc);
    int first, cnt, bad;
    first = -1; cnt = 0; bad = 0;
    for (int c = 1; c <= cap_n; c++) begin
      if (cap_done[c] === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
      end
      if (cap_busy[c] !== ((c < done_cyc) ? 1'b1 : 1'b0)) bad++;
    end
    check({tag, "_done_cycle"}, first, done_cyc);
    check({tag, "_done_count"}, cnt, 1);
    check({tag, "_busy_bad_cycles"}, bad, 0);
  endtask

  // Start is sampled at edge 0; sample index c is the negedge inside cycle c.
  task automatic capture(input int ncyc, input bit hold_start, input bit perturb);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    cap_n = ncyc;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cap_tag[c]  = tag_data;
      cap_busy[c] = busy;
      cap_done[c] = done;
      if (perturb) begin
        start = (c == 30 || c == 100) ? 1'b1 : 1'b0;
        if (c == 40) begin
          osc = 5'h0a;
          ds  = 8'hff;
          sel = 2'b10;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic load_cfg(input bit with_init);
    init = with_init;
    osc  = 5'h15;
    ds   = 8'h03;
    sel  = 2'b01;
  endtask

  int v;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    load_cfg(1'b0);
    repeat (3) @(negedge clk);
    check("reset_tag", int'(tag_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain config sequence; start pulses and input changes mid-run must be ignored.
    load_cfg(1'b0);
    capture(160, 1'b0, 1'b1);
    v = 0;
    for (int c = 1; c <= 4; c++) v |= int'(cap_tag[c]) << (c - 1);
    check("a_gap_bits", v, 0);
    v = 0;
    for (int c = 5; c <= 16; c++) v |= int'(cap_tag[c]) << (c - 5);
    check("a_p0_bits", v, 'h8c1);
    check_done_busy("a", 150);
    set_pkts(1'b0);
    build_stream();
    check_stream("a");
    check_pkts("a");

    // With client-reset prefix.
    @(negedge clk);
    load_cfg(1'b1);
    capture(260, 1'b0, 1'b0);
    v = 0;
    for (int c = 5; c <= 16; c++) v |= int'(cap_tag[c]) << (c - 5);
    check("b_p0_bits", v, 'h081);
    check_done_busy("b", 243);
    set_pkts(1'b1);
    build_stream();
    check_stream("b");
    check_pkts("b");

    // Asynchronous reset during the P4 payload (cycles 84..92), then a clean restart.
    @(negedge clk);
    load_cfg(1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 86; c++) @(negedge clk);
    check("c_p4_bit2_before_reset", int'(tag_data), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("c_async_tag", int'(tag_data), 0);
    check("c_async_busy", int'(busy), 0);
    check("c_async_done", int'(done), 0);
    repeat (3) @(negedge clk);
    check("c_held_busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("c_idle_after_release", int'(busy), 0);
    load_cfg(1'b0);
    capture(160, 1'b0, 1'b0);
    check_done_busy("c", 150);
    set_pkts(1'b0);
    build_stream();
    check_stream("c");
    check_pkts("c");

    // start held high: back-to-back sequences separated by one DONE and one IDLE cycle.
    @(negedge clk);
    load_cfg(1'b0);
    capture(305, 1'b1, 1'b0);
    v = 0;
    for (int c = 1; c <= cap_n; c++) if (cap_done[c] === 1'b1) v++;
    check("d_done_count", v, 2);
    check("d_done_150", int'(cap_done[150]), 1);
    check("d_done_151", int'(cap_done[151]), 0);
    check("d_done_301", int'(cap_done[301]), 1);
    check("d_busy_150", int'(cap_busy[150]), 0);
    check("d_busy_151", int'(cap_busy[151]), 0);
    check("d_busy_152", int'(cap_busy[152]), 1);
    set_pkts(1'b0);
    build_stream();
    for (int k = 1; k <= 149; k++) exp_bits[151 + k] = exp_bits[k];
    check_stream("d");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
